// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter
// Shares one read-only system-ID slave (1-bit address, combinational
// readdata) among NUM_REQ requesters. Round-robin arbitration, one read in
// flight, response returned as a one-cycle one-hot valid pulse.
//
// Optional feature: define SYSID_ARB_CACHE_EN to add a two-entry read cache
// (one entry per slave address) and the cache_flush input.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   req_read[NUM_REQ]    per-requester read request (level)
//   req_address[NUM_REQ] per-requester word select (0 = ID, 1 = timestamp)
//   cache_flush          (cache build only) invalidate both cache entries
//   rsp_valid[NUM_REQ]   one-hot, one-cycle response strobe
//   rsp_data             registered response data, shared by all requesters
//   slv_address          address presented to the slave
//   slv_readdata         slave read data
//   busy                 high while a transaction is in progress
//   grant_id             index of the current or last granted requester
module sysid_read_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_W       = 32,
  parameter int  READ_LATENCY = 0,
  localparam int IDX_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_address,
`ifdef SYSID_ARB_CACHE_EN
  input  logic               cache_flush,
`endif
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               slv_address,
  input  logic [DATA_W-1:0]  slv_readdata,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic             sample;
  logic             hit;
  logic [2:0]       wait_cnt;

`ifdef SYSID_ARB_CACHE_EN
  logic [1:0]        cache_vld;
  logic [DATA_W-1:0] cache_data [2];

  assign hit = cache_vld[req_address[winner]];
`else
  assign hit = 1'b0;
`endif

  // Round-robin pick: first requester at or after rr_ptr+1, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_ptr;
    cand    = rr_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req_read[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // sample marks the edge at which slv_readdata is captured into rsp_data.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = hit ? RESP : ISSUE;
      end
      ISSUE: begin
        if (READ_LATENCY == 0) begin
          sample     = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          sample     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid   <= '0;
      rsp_data    <= '0;
      slv_address <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      wait_cnt    <= '0;
    end else begin
      rsp_valid <= '0;
      // Grant: address and winner are frozen here for the whole transaction.
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        rr_ptr   <= winner;
`ifdef SYSID_ARB_CACHE_EN
        if (hit) begin
          rsp_data  <= cache_data[req_address[winner]];
          rsp_valid <= NUM_REQ'(1) << winner;
        end else
`endif
        slv_address <= req_address[winner];
      end
      if (state == ISSUE && READ_LATENCY != 0) begin
        wait_cnt <= 3'(READ_LATENCY - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      // Capture: response strobe goes out in the following (RESP) cycle.
      if (sample) begin
        rsp_data  <= slv_readdata;
        rsp_valid <= NUM_REQ'(1) << grant_id;
      end
    end
  end

`ifdef SYSID_ARB_CACHE_EN
  // Flush has priority over a fill landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset)            cache_vld <= '0;
    else if (cache_flush) cache_vld <= '0;
    else if (sample)      cache_vld[slv_address] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (sample) cache_data[slv_address] <= slv_readdata;
  end
`endif

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: one instance with READ_LATENCY=0 for directed
// reads (and the cache when SYSID_ARB_CACHE_EN is defined), one with
// READ_LATENCY=2 tracked cycle by cycle against a transaction-level model.
module tb_sysid_read_arbiter;
  localparam int          NUM_REQ = 4;
  localparam int          LAT     = 2;
  localparam logic [31:0] A_TS    = 32'h5191A123;
  localparam logic [31:0] A_ID    = 32'h00051D00;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]  req_read_a, req_address_a, rsp_valid_a;
  logic [31:0] rsp_data_a, slv_readdata_a;
  logic        slv_address_a, busy_a;
  logic [1:0]  grant_id_a;

  logic [3:0]  req_read_b, req_address_b, rsp_valid_b;
  logic [31:0] rsp_data_b, slv_readdata_b, id_word, ts_word;
  logic        slv_address_b, busy_b;
  logic [1:0]  grant_id_b;

`ifdef SYSID_ARB_CACHE_EN
  logic cache_flush_a, cache_flush_b;
`endif

  assign slv_readdata_a = slv_address_a ? A_TS : A_ID;
  assign slv_readdata_b = slv_address_b ? ts_word : id_word;

  sysid_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(32), .READ_LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset), .req_read(req_read_a), .req_address(req_address_a),
`ifdef SYSID_ARB_CACHE_EN
    .cache_flush(cache_flush_a),
`endif
    .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .slv_address(slv_address_a),
    .slv_readdata(slv_readdata_a), .busy(busy_a), .grant_id(grant_id_a));

  sysid_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(32), .READ_LATENCY(LAT)) u_lat2 (
    .clock(clock), .reset(reset), .req_read(req_read_b), .req_address(req_address_b),
`ifdef SYSID_ARB_CACHE_EN
    .cache_flush(cache_flush_b),
`endif
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .slv_address(slv_address_b),
    .slv_readdata(slv_readdata_b), .busy(busy_b), .grant_id(grant_id_b));

  int checks, errors, cyc;

  // Transaction-level model of u_lat2: when the arbiter is next free, the
  // cycle the pending response appears, and what it carries.
  int          idle_from, resp_cycle, rr;
  logic [3:0]  resp_oh, granted;
  logic [31:0] resp_dat, exp_data;
  logic [1:0]  exp_grant;
  logic        exp_addr;
  int          waits [NUM_REQ];
  int          pulse_cyc [$];
  int          pulse_id [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    idle_from  = cyc;
    resp_cycle = -100;
    resp_oh    = '0;
    resp_dat   = '0;
    exp_data   = '0;
    exp_grant  = '0;
    exp_addr   = 1'b0;
    rr         = NUM_REQ - 1;
    granted    = '0;
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    cyc++;
    model_reset();
  endtask

  // Check u_lat2 in the current cycle, let the model arbitrate on the inputs
  // now applied, then advance one clock.
  task automatic step_b();
    logic [3:0] ev;
    int w;
    ev = (cyc == resp_cycle) ? resp_oh : 4'b0000;
    if (cyc == resp_cycle) begin
      exp_data = resp_dat;
      granted  = granted & ~resp_oh;
    end
    chk("rsp_valid", {28'd0, rsp_valid_b}, {28'd0, ev});
    chk("rsp_data", rsp_data_b, exp_data);
    chk("busy", {31'd0, busy_b}, {31'd0, (cyc < idle_from)});
    chk("grant_id", {30'd0, grant_id_b}, {30'd0, exp_grant});
    chk("slv_address", {31'd0, slv_address_b}, {31'd0, exp_addr});
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid_b[i]) begin
        pulse_cyc.push_back(cyc);
        pulse_id.push_back(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) if (!req_read_b[i]) waits[i] = 0;
    if (cyc >= idle_from && req_read_b != 4'b0000) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (w < 0 && req_read_b[(rr + k) % NUM_REQ]) w = (rr + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == w) waits[i] = 0;
        else if (req_read_b[i]) begin
          waits[i]++;
          chk("fairness", {31'd0, (waits[i] <= NUM_REQ - 1)}, 32'd1);
        end
      end
      rr         = w;
      exp_grant  = 2'(w);
      exp_addr   = req_address_b[w];
      resp_oh    = 4'(1 << w);
      resp_dat   = exp_addr ? ts_word : id_word;
      resp_cycle = cyc + 2 + LAT;
      idle_from  = cyc + 3 + LAT;
      granted[w] = 1'b1;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  // Protocol-respecting random requesters: a pending, ungranted request is
  // held; granted requesters may drop; finished ones may re-request.
  task automatic rand_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted[i]) begin
        req_read_b[i]    = 1'($urandom);
        req_address_b[i] = 1'($urandom);
      end else if (req_read_b[i]) begin
        if ($urandom_range(0, 3) == 0) req_address_b[i] = ~req_address_b[i];
      end else if ($urandom_range(0, 2) == 0) begin
        req_read_b[i]    = 1'b1;
        req_address_b[i] = 1'($urandom);
      end
    end
  endtask

  task automatic read_a(input int r, input logic a, output int lat, output logic [31:0] dat);
    req_address_a[r] = a;
    req_read_a[r]    = 1'b1;
    lat = -1;
    dat = '0;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      step_b();
      if (rsp_valid_a != 4'b0000) begin
        lat = k;
        dat = rsp_data_a;
        chk("a_onehot", {28'd0, rsp_valid_a}, {28'd0, 4'(1 << r)});
      end
    end
    req_read_a = '0;
    step_b();
  endtask

  initial begin
    int          lat;
    logic [31:0] dat;
    checks = 0; errors = 0; cyc = 0;
    req_read_a = '0; req_address_a = '0;
    req_read_b = '0; req_address_b = '0;
    id_word = $urandom;
    ts_word = $urandom;
`ifdef SYSID_ARB_CACHE_EN
    cache_flush_a = 1'b1;
    cache_flush_b = 1'b1;
`endif
    apply_reset();
    chk("a_rst_valid", {28'd0, rsp_valid_a}, 32'd0);
    chk("a_rst_data", rsp_data_a, 32'd0);
    chk("a_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("a_rst_grant", {30'd0, grant_id_a}, 32'd0);
    chk("a_rst_addr", {31'd0, slv_address_a}, 32'd0);

    // Single read of the timestamp word, zero latency.
    req_read_a = 4'b0001; req_address_a = 4'b0001;
    step_b();
    chk("a_t1_valid", {28'd0, rsp_valid_a}, 32'd0);
    chk("a_t1_busy", {31'd0, busy_a}, 32'd1);
    step_b();
    chk("a_t2_valid", {28'd0, rsp_valid_a}, 32'b0001);
    chk("a_t2_data", rsp_data_a, A_TS);
    chk("a_t2_addr", {31'd0, slv_address_a}, 32'd1);
    chk("a_t2_grant", {30'd0, grant_id_a}, 32'd0);
    req_read_a = 4'b0000;
    step_b();
    chk("a_t3_valid", {28'd0, rsp_valid_a}, 32'd0);
    chk("a_t3_busy", {31'd0, busy_a}, 32'd0);
    chk("a_t3_hold", rsp_data_a, A_TS);

    // Simultaneous 0 and 2 after 0 was last served: 2 wins, then 0.
    req_read_a = 4'b0101; req_address_a = 4'b0000;
    step_b(); step_b();
    chk("a_rr_valid", {28'd0, rsp_valid_a}, 32'b0100);
    chk("a_rr_grant", {30'd0, grant_id_a}, 32'd2);
    chk("a_rr_data", rsp_data_a, A_ID);
    chk("a_rr_addr", {31'd0, slv_address_a}, 32'd0);
    req_read_a = 4'b0001;
    step_b(); step_b(); step_b();
    chk("a_rr2_valid", {28'd0, rsp_valid_a}, 32'b0001);
    req_read_a = 4'b0000;
    step_b();

    // All four requesting continuously.
    apply_reset();
    req_read_b = 4'b1111; req_address_b = 4'($urandom);
    pulse_cyc.delete(); pulse_id.delete();
    for (int n = 0; n < 25; n++) step_b();
    chk("rr_count", pulse_id.size(), 32'd5);
    if (pulse_id.size() == 5) begin
      for (int n = 0; n < 5; n++) chk("rr_order", pulse_id[n], n % NUM_REQ);
      for (int n = 0; n < 4; n++) chk("rr_spacing", pulse_cyc[n+1] - pulse_cyc[n], 3 + LAT);
    end
    req_read_b = '0;
    for (int n = 0; n < 4; n++) step_b();

    // Requester 1 changes address and drops request right after its grant.
    req_read_b = 4'b0010; req_address_b = 4'b0010;
    step_b();
    req_read_b[1] = 1'b0; req_address_b[1] = 1'b0;
    step_b(); step_b(); step_b();
    chk("late_valid", {28'd0, rsp_valid_b}, 32'b0010);
    chk("late_data", rsp_data_b, ts_word);
    for (int n = 0; n < 3; n++) step_b();

    // Reset while requester 2 waits on the slave.
    req_read_b = 4'b0100; req_address_b = 4'b0000;
    step_b(); step_b();
    req_read_b = 4'b1111;
    apply_reset();
    chk("mid_rst_valid", {28'd0, rsp_valid_b}, 32'd0);
    chk("mid_rst_data", rsp_data_b, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_b}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_id_b}, 32'd0);
    pulse_id.delete(); pulse_cyc.delete();
    for (int n = 0; n < 5; n++) step_b();
    chk("mid_rst_pulses", pulse_id.size(), 32'd1);
    if (pulse_id.size() > 0) chk("mid_rst_first", pulse_id[0], 32'd0);
    req_read_b = '0;
    for (int n = 0; n < 4; n++) step_b();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      step_b();
    end
    req_read_b = '0;
    for (int n = 0; n < 8; n++) step_b();

`ifdef SYSID_ARB_CACHE_EN
    cache_flush_a = 1'b0;
    read_a(3, 1'b0, lat, dat);
    chk("c_miss0_lat", lat, 32'd2);
    chk("c_miss0_data", dat, A_ID);
    read_a(3, 1'b1, lat, dat);
    chk("c_miss1_lat", lat, 32'd2);
    chk("c_miss1_data", dat, A_TS);
    read_a(3, 1'b0, lat, dat);
    chk("c_hit0_lat", lat, 32'd1);
    chk("c_hit0_data", dat, A_ID);
    chk("c_hit0_addr", {31'd0, slv_address_a}, 32'd1);
    cache_flush_a = 1'b1;
    step_b();
    cache_flush_a = 1'b0;
    read_a(3, 1'b0, lat, dat);
    chk("c_flush_lat", lat, 32'd2);
    chk("c_flush_data", dat, A_ID);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
